// File: rtl/zx_ps2_matrix.sv
`default_nettype none
// ============================================================================
//  Module   : zx_ps2_matrix
//  Purpose  : PS/2 set-2 scancode stream to ZX Spectrum 8x5 keyboard matrix,
//             read back through port FEh. Optional virtual cursor/backspace
//             keys are enabled by defining ZXKBD_EXTKEYS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module zx_ps2_matrix #(
   parameter int PAUSE_SKIP = 7
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        ps2_data_clk,
   input  logic [7:0]  ps2_data,
   input  logic [15:0] A,
   output logic [7:0]  D
);

   // Flat key vector: 0..39 matrix (row*5+bit), then shift/ctrl flags,
   // then virtual keys when enabled.
`ifdef ZXKBD_EXTKEYS_EN
   localparam int c_NK = 49;
`else
   localparam int c_NK = 44;
`endif
   localparam logic [5:0] c_LSHIFT = 6'd40;
   localparam logic [5:0] c_RSHIFT = 6'd41;
   localparam logic [5:0] c_LCTRL  = 6'd42;
   localparam logic [5:0] c_RCTRL  = 6'd43;
   localparam logic [7:0] c_SKIP_LOAD = 8'(PAUSE_SKIP);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EXT    = 3'd1,
      ST_BRK    = 3'd2,
      ST_EXTBRK = 3'd3,
      ST_SKIP   = 3'd4
   } state_t;

   state_t          r_state;
   logic [7:0]      r_skip;
   logic [c_NK-1:0] r_keys;

   logic            w_ext;
   logic [6:0]      w_map;
   logic            w_hit;
   logic [5:0]      w_idx;
   logic [4:0]      w_virt;
   logic            w_vcaps;
   logic [4:0]      w_row [8];
   logic [4:0]      w_or;
   logic            w_unused_addr;

   function automatic logic [6:0] map_normal(input logic [7:0] code);
      case (code)
         8'h1A: map_normal = {1'b1, 6'd1};
         8'h22: map_normal = {1'b1, 6'd2};
         8'h21: map_normal = {1'b1, 6'd3};
         8'h2A: map_normal = {1'b1, 6'd4};
         8'h1C: map_normal = {1'b1, 6'd5};
         8'h1B: map_normal = {1'b1, 6'd6};
         8'h23: map_normal = {1'b1, 6'd7};
         8'h2B: map_normal = {1'b1, 6'd8};
         8'h34: map_normal = {1'b1, 6'd9};
         8'h15: map_normal = {1'b1, 6'd10};
         8'h1D: map_normal = {1'b1, 6'd11};
         8'h24: map_normal = {1'b1, 6'd12};
         8'h2D: map_normal = {1'b1, 6'd13};
         8'h2C: map_normal = {1'b1, 6'd14};
         8'h16: map_normal = {1'b1, 6'd15};
         8'h1E: map_normal = {1'b1, 6'd16};
         8'h26: map_normal = {1'b1, 6'd17};
         8'h25: map_normal = {1'b1, 6'd18};
         8'h2E: map_normal = {1'b1, 6'd19};
         8'h45: map_normal = {1'b1, 6'd20};
         8'h46: map_normal = {1'b1, 6'd21};
         8'h3E: map_normal = {1'b1, 6'd22};
         8'h3D: map_normal = {1'b1, 6'd23};
         8'h36: map_normal = {1'b1, 6'd24};
         8'h4D: map_normal = {1'b1, 6'd25};
         8'h44: map_normal = {1'b1, 6'd26};
         8'h43: map_normal = {1'b1, 6'd27};
         8'h3C: map_normal = {1'b1, 6'd28};
         8'h35: map_normal = {1'b1, 6'd29};
         8'h5A: map_normal = {1'b1, 6'd30};
         8'h4B: map_normal = {1'b1, 6'd31};
         8'h42: map_normal = {1'b1, 6'd32};
         8'h3B: map_normal = {1'b1, 6'd33};
         8'h33: map_normal = {1'b1, 6'd34};
         8'h29: map_normal = {1'b1, 6'd35};
         8'h3A: map_normal = {1'b1, 6'd37};
         8'h31: map_normal = {1'b1, 6'd38};
         8'h32: map_normal = {1'b1, 6'd39};
         8'h12: map_normal = {1'b1, c_LSHIFT};
         8'h59: map_normal = {1'b1, c_RSHIFT};
         8'h14: map_normal = {1'b1, c_LCTRL};
`ifdef ZXKBD_EXTKEYS_EN
         8'h66: map_normal = {1'b1, 6'd44};
`endif
         default: map_normal = 7'd0;
      endcase
   endfunction

   // E0 12h (fake shift) is deliberately absent from the extended map.
   function automatic logic [6:0] map_ext(input logic [7:0] code);
      case (code)
         8'h14: map_ext = {1'b1, c_RCTRL};
`ifdef ZXKBD_EXTKEYS_EN
         8'h6B: map_ext = {1'b1, 6'd45};
         8'h72: map_ext = {1'b1, 6'd46};
         8'h75: map_ext = {1'b1, 6'd47};
         8'h74: map_ext = {1'b1, 6'd48};
`endif
         default: map_ext = 7'd0;
      endcase
   endfunction

   assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXTBRK);
   assign w_map = w_ext ? map_ext(ps2_data) : map_normal(ps2_data);
   assign w_hit = w_map[6];
   assign w_idx = w_map[5:0];

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_skip  <= '0;
         r_keys  <= '0;
      end else if (ps2_data_clk) begin
         case (r_state)
            ST_IDLE: begin
               if (ps2_data == 8'hF0) begin
                  r_state <= ST_BRK;
               end else if (ps2_data == 8'hE0) begin
                  r_state <= ST_EXT;
               end else if (ps2_data == 8'hE1) begin
                  if (PAUSE_SKIP > 0) begin
                     r_state <= ST_SKIP;
                     r_skip  <= c_SKIP_LOAD;
                  end
               end else if (ps2_data == 8'hAA) begin
                  r_keys <= '0;
               end else if (w_hit) begin
                  r_keys[w_idx] <= 1'b1;
               end
            end
            ST_EXT: begin
               if (ps2_data == 8'hF0) begin
                  r_state <= ST_EXTBRK;
               end else begin
                  if (w_hit) r_keys[w_idx] <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_BRK, ST_EXTBRK: begin
               if (w_hit) r_keys[w_idx] <= 1'b0;
               r_state <= ST_IDLE;
            end
            ST_SKIP: begin
               r_skip <= r_skip - 8'd1;
               if (r_skip <= 8'd1) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef ZXKBD_EXTKEYS_EN
   assign w_virt = r_keys[48:44];
`else
   assign w_virt = 5'd0;
`endif
   assign w_vcaps = |w_virt;

   // Virtual keys act as CAPS SHIFT plus a digit: BS=0, left=5, down=6, up=7, right=8.
   always_comb begin
      for (int r = 0; r < 8; r++) w_row[r] = r_keys[r*5 +: 5];
      w_row[0][0] = r_keys[0] | r_keys[c_LSHIFT] | r_keys[c_RSHIFT] | w_vcaps;
      w_row[7][1] = r_keys[36] | r_keys[c_LCTRL] | r_keys[c_RCTRL];
      w_row[4][0] = r_keys[20] | w_virt[0];
      w_row[3][4] = r_keys[19] | w_virt[1];
      w_row[4][4] = r_keys[24] | w_virt[2];
      w_row[4][3] = r_keys[23] | w_virt[3];
      w_row[4][2] = r_keys[22] | w_virt[4];
   end

   always_comb begin
      w_or = 5'd0;
      for (int r = 0; r < 8; r++) begin
         if (!A[8+r]) w_or = w_or | w_row[r];
      end
   end

   assign D = {3'b111, ~w_or};
   assign w_unused_addr = ^A[7:0];

endmodule
`default_nettype wire

// File: tb/tb_zx_ps2_matrix.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zx_ps2_matrix
//  Purpose  : Scoreboard bench for zx_ps2_matrix port FEh reads.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_zx_ps2_matrix;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_data_clk = 1'b0;
   logic [7:0]  ps2_data = 8'h00;
   logic [15:0] A = 16'hFFFE;
   logic [7:0]  D;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [7:0]  sbq[$];
   logic [4:0]  mrow [8];
   logic [7:0]  kcode [38];
   int          krow [38];
   int          kbit [38];

   zx_ps2_matrix #(.PAUSE_SKIP(7)) dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .ps2_data_clk (ps2_data_clk),
      .ps2_data     (ps2_data),
      .A            (A),
      .D            (D)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: D=%02h expected %02h", tag, got, exp);
      end
   endtask

   // Caller is always #1 after a rising edge; strobes sent back to back land on consecutive edges.
   task automatic send(input logic [7:0] b);
      ps2_data     = b;
      ps2_data_clk = 1'b1;
      @(posedge CLOCK_50);
      #1;
      ps2_data_clk = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
      A = addr;
      sbq.push_back(exp);
      #2;
      chk(tag, D, sbq.pop_front());
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge CLOCK_50);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [7:0] model_d(input logic [15:0] addr);
      logic [4:0] o;
      o = 5'd0;
      for (int r = 0; r < 8; r++) if (!addr[8+r]) o = o | mrow[r];
      return {3'b111, ~o};
   endfunction

   initial begin
      kcode = '{8'h1A,8'h22,8'h21,8'h2A, 8'h1C,8'h1B,8'h23,8'h2B,8'h34,
                8'h15,8'h1D,8'h24,8'h2D,8'h2C, 8'h16,8'h1E,8'h26,8'h25,8'h2E,
                8'h45,8'h46,8'h3E,8'h3D,8'h36, 8'h4D,8'h44,8'h43,8'h3C,8'h35,
                8'h5A,8'h4B,8'h42,8'h3B,8'h33, 8'h29,8'h3A,8'h31,8'h32};
      krow  = '{0,0,0,0, 1,1,1,1,1, 2,2,2,2,2, 3,3,3,3,3,
                4,4,4,4,4, 5,5,5,5,5, 6,6,6,6,6, 7,7,7,7};
      kbit  = '{1,2,3,4, 0,1,2,3,4, 0,1,2,3,4, 0,1,2,3,4,
                0,1,2,3,4, 0,1,2,3,4, 0,1,2,3,4, 0,2,3,4};

      // Strobe during reset must be dropped.
      @(posedge CLOCK_50);
      #1;
      ps2_data = 8'h1C;
      ps2_data_clk = 1'b1;
      @(posedge CLOCK_50);
      #1;
      ps2_data_clk = 1'b0;
      reset = 1'b0;
      for (int r = 0; r < 8; r++) rd("reset_sweep", {~(8'd1 << r), 8'hFE}, 8'hFF);

      send(8'h1C);
      rd("a_make", 16'hFDFE, 8'hFE);
      send(8'hF0); send(8'h1C);
      rd("a_break", 16'hFDFE, 8'hFF);

      send(8'h12); send(8'h59); send(8'hF0); send(8'h12);
      rd("rshift_held", 16'hFEFE, 8'hFE);
      send(8'hF0); send(8'h59);
      rd("shifts_up", 16'hFEFE, 8'hFF);

      send(8'h29); send(8'h15);
      rd("rows27", 16'h7BFE, 8'hFE);
      rd("all_rows", 16'h00FE, 8'hFE);
      rd("row2_only_w", 16'hFBFE, 8'hFE);
      send(8'hF0); send(8'h29); send(8'hF0); send(8'h15);
      rd("rows27_up", 16'h00FE, 8'hFF);

      send(8'hE1);
      send(8'h1C); send(8'h77); send(8'hE1); send(8'hF0);
      send(8'h14); send(8'hF0); send(8'h77);
      rd("pause_a", 16'hFDFE, 8'hFF);
      rd("pause_all", 16'h00FE, 8'hFF);
      send(8'h1C);
      rd("after_pause", 16'hFDFE, 8'hFE);
      send(8'hF0); send(8'h1C);

      send(8'hE0); send(8'h14);
      rd("rctrl", 16'h7FFE, 8'hFD);
      send(8'h14); send(8'hE0); send(8'hF0); send(8'h14);
      rd("lctrl_held", 16'h7FFE, 8'hFD);
      send(8'hF0); send(8'h14);
      rd("ctrl_up", 16'h7FFE, 8'hFF);

      send(8'h1A); send(8'h1A); send(8'hF0); send(8'h1A);
      rd("repeat_make", 16'hFEFE, 8'hFF);

      send(8'hE0); send(8'h12);
      rd("fake_shift", 16'hFEFE, 8'hFF);
      send(8'hE0); send(8'hF0); send(8'h12);

      send(8'hF0);
      pulse_reset();
      send(8'h1C);
      rd("reset_mid_brk", 16'hFDFE, 8'hFE);

      send(8'h29); send(8'h45);
      rd("pre_clear", 16'h00FE, 8'hFE);
      send(8'hFA); send(8'hEE); send(8'hFF); send(8'h00);
      rd("ignored", 16'h00FE, 8'hFE);
      send(8'hAA);
      rd("aa_clear", 16'h00FE, 8'hFF);

`ifdef ZXKBD_EXTKEYS_EN
      send(8'h12);
      send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B);
      rd("vk_caps_held", 16'hFEFE, 8'hFE);
      rd("vk_left_up", 16'hF7FE, 8'hFF);
      send(8'hE0); send(8'h6B);
      rd("vk_left", 16'hF7FE, 8'hEF);
      send(8'hF0); send(8'h12);
      rd("vk_caps_virt", 16'hFEFE, 8'hFE);
      send(8'hE0); send(8'hF0); send(8'h6B);
      rd("vk_all_up", 16'hFEFE, 8'hFF);
      send(8'h66); send(8'hE0); send(8'h75);
      rd("vk_bs_up", 16'hEFFE, 8'hF6);
      send(8'hE0); send(8'h72); send(8'hE0); send(8'h74);
      rd("vk_4keys", 16'hEFFE, 8'hE2);
      send(8'hAA);
      rd("vk_clear", 16'h00FE, 8'hFF);
`else
      send(8'h66); send(8'hE0); send(8'h6B); send(8'hE0); send(8'h75);
      rd("vk_absent", 16'h00FE, 8'hFF);
`endif

      // Random make/break of plain keys against a table-driven model.
      for (int r = 0; r < 8; r++) mrow[r] = 5'd0;
      for (int i = 0; i < 80; i++) begin
         int k;
         logic [15:0] addr;
         k = $urandom_range(37);
         if ($urandom_range(1) == 0) begin
            send(kcode[k]);
            mrow[krow[k]][kbit[k]] = 1'b1;
         end else begin
            send(8'hF0); send(kcode[k]);
            mrow[krow[k]][kbit[k]] = 1'b0;
         end
         addr = {8'($urandom), 8'hFE};
         rd("rand", addr, model_d(addr));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/zx_ps2_matrix.md
# zx_ps2_matrix

PS/2-to-ZX-Spectrum keyboard matrix. It consumes the decoded set-2 byte stream from the PS/2 physical receiver and keeps an 8×5 key-state matrix. It answers Z80 reads of port FEh with the active-low key bits for the half-rows selected by the high address byte. It sits between the PS/2 receiver and the top-level I/O read mux, which drives `D` onto the CPU bus when `nIORQ=0`, `nRD=0` and `A[7:0]=FEh`.

## Interface
Parameters:
- `PAUSE_SKIP`, default 7: bytes discarded after an E1 (Pause) prefix.

Ports:
- `CLOCK_50`  in  1  : single clock.
- `reset`  in  1  : synchronous, active-high reset.
- `ps2_data_clk`  in  1  : one-cycle strobe; `ps2_data` is valid this cycle.
- `ps2_data`  in  8  : received set-2 scancode byte.
- `A`  in  16  : Z80 address bus; `A[15:8]` selects half-rows (0 = selected).
- `D`  out  8  : port FEh read value. `D[7:5]=3'b111`; `D[4:0]` active-low keys.

## Operation
- Matrix: `row[r][b]`, r=0..7 (r selected by `A[8+r]=0`), b=0..4; 1 = pressed internally. Physical key codes, with bits b0..b4:
  - r0: CAPS SHIFT (12h, 59h), Z 1Ah, X 22h, C 21h, V 2Ah
  - r1: A 1Ch, S 1Bh, D 23h, F 2Bh, G 34h
  - r2: Q 15h, W 1Dh, E 24h, R 2Dh, T 2Ch
  - r3: 1 16h, 2 1Eh, 3 26h, 4 25h, 5 2Eh
  - r4: 0 45h, 9 46h, 8 3Eh, 7 3Dh, 6 36h
  - r5: P 4Dh, O 44h, I 43h, U 3Ch, Y 35h
  - r6: ENTER 5Ah, L 4Bh, K 42h, J 3Bh, H 33h
  - r7: SPACE 29h, SYM SHIFT (14h, E0 14h), M 3Ah, N 31h, B 32h
- Left and right shift are independent flags; CAPS SHIFT = OR of both. The same applies to the two Ctrl keys for SYM SHIFT.
- `D[4:0] = ~(OR over r with A[8+r]=0 of row[r])`. If no row is selected, `D = FFh`. Combinational from registers and `A`.
- Prefix FSM, advanced only on `ps2_data_clk`:
  - IDLE: F0 → BRK; E0 → EXT; E1 → SKIP (counter loaded with `PAUSE_SKIP`); AAh → clear all keys and stay in IDLE; 00h/FAh/FEh/EEh/FFh → ignored; other codes → press the mapped key.
  - EXT: F0 → EXTBRK; other codes → press the extended map key, then IDLE.
  - BRK / EXTBRK: a code releases the mapped key (normal or extended map), then IDLE.
  - SKIP: each byte decrements the counter; return to IDLE when it reaches 0.
- Unmapped codes in any state cause no matrix change; the FSM still returns to IDLE.
- E0 12h / E0 F0 12h (fake shift) are unmapped and ignored.
- Repeated make codes while a key is already pressed cause no change.

## Timing
- Reset values: every matrix bit 0, every virtual key 0, FSM = IDLE, skip counter 0. So `D = FFh` one cycle after reset for any `A`.
- A strobe during `reset=1` is discarded.
- Latency: a strobe at edge N updates the registers at edge N. `D` reflects the change immediately after edge N; `A` changes reflect in `D` combinationally.
- There is no back-pressure. Strobes may arrive on consecutive cycles; each is processed fully in its own cycle.
- Reset mid-prefix (e.g. after F0) returns the FSM to IDLE, so the next code is treated as a make.

## Configuration
- `ZXKBD_EXTKEYS_EN` defined: enables virtual keys, each held in its own flag and ORed into CAPS SHIFT plus the digit bit:
  - Backspace 66h → CAPS+0
  - E0 6Bh (left) → CAPS+5
  - E0 72h (down) → CAPS+6
  - E0 75h (up) → CAPS+7
  - E0 74h (right) → CAPS+8
  - Releasing a virtual key clears only its own flag; a physically held shift stays asserted.
- Undefined: these codes are unmapped and no virtual-key flags exist. E0 14h remains mapped.

## Test plan
- Reset, then sweep `A=FEFEh`..`7FFEh` → `D=FFh` for every value.
- Strobe 1Ch, then `A=FDFEh` → `D=FEh`. Strobe F0, 1Ch, then `A=FDFEh` → `D=FFh`.
- Strobe 12h and 59h, then F0 12h, then `A=FEFEh` → `D=FEh` (right shift still held). Strobe F0 59h → `D=FFh`.
- Strobe 29h and 15h, then `A=7BFEh` (rows 2 and 7) → `D=FEh`. `A=00FEh` → `D=FEh`.
- Strobe E1 plus 7 arbitrary bytes (including 1Ch), then `A=FDFEh` → `D=FFh`. A following 1Ch → `D=FEh`.
- With `ZXKBD_EXTKEYS_EN`: strobe 12h, E0 6Bh, E0 F0 6Bh, then `A=FEFEh` → `D=FEh` (CAPS still pressed) and `A=F7FEh` → `D=FFh`. Strobe AAh → all rows read FFh.
